// File: rtl/demux_lane_merger.sv
// demux_lane_merger: recombines the two lane streams of a 1:2 demux.
// Each lane is buffered in its own circular FIFO. A round-robin arbiter
// drains both FIFOs into a registered output stage that tags every word
// with the lane it came from.
module demux_lane_merger #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lane,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  lane0_count,
  output logic [CNT_W-1:0]  lane1_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-lane views so both FIFOs share one generate body.
  logic [1:0]              in_valid_s;
  logic [1:0][DATA_W-1:0]  in_data_s;
  logic [1:0]              ready_s;
  logic [1:0]              push_s;
  logic [1:0]              pop_s;
  logic [1:0]              not_empty_s;
  logic [1:0][DATA_W-1:0]  head_s;
  logic [1:0][CNT_W-1:0]   cnt_s;
  logic                    load_en_s;
  logic                    last_grant_r;

  assign in_valid_s = {in1_valid, in0_valid};
  assign in_data_s  = {in1_data, in0_data};

  assign in0_ready   = ready_s[0];
  assign in1_ready   = ready_s[1];
  assign lane0_count = cnt_s[0];
  assign lane1_count = cnt_s[1];

  // The output stage may take a new word when empty or being drained.
  assign load_en_s = !out_valid || out_ready;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_r;
    logic [PTR_W-1:0]  rd_r;
    logic [CNT_W-1:0]  cnt_r;

    // Ready depends only on the registered count, so a full FIFO never
    // accepts a word even when it is being popped in the same cycle.
    assign ready_s[l]     = (cnt_r != CNT_W'(DEPTH));
    assign push_s[l]      = in_valid_s[l] && ready_s[l];
    assign not_empty_s[l] = (cnt_r != {CNT_W{1'b0}});
    assign head_s[l]      = mem_r[rd_r];
    assign cnt_s[l]       = cnt_r;

    // Storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
      if (push_s[l]) begin
        mem_r[wr_r] <= in_data_s[l];
      end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_r  <= {PTR_W{1'b0}};
        rd_r  <= {PTR_W{1'b0}};
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        if (push_s[l]) begin
          wr_r <= wr_r + PTR_W'(1);
        end
        if (pop_s[l]) begin
          rd_r <= rd_r + PTR_W'(1);
        end
        case ({push_s[l], pop_s[l]})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  // Round-robin grant: on a tie the lane that did not win last time goes.
  always_comb begin
    pop_s = 2'b00;
    if (load_en_s) begin
      if (not_empty_s[0] && not_empty_s[1]) begin
        if (last_grant_r) begin
          pop_s = 2'b01;
        end else begin
          pop_s = 2'b10;
        end
      end else if (not_empty_s[0]) begin
        pop_s = 2'b01;
      end else if (not_empty_s[1]) begin
        pop_s = 2'b10;
      end else begin
        pop_s = 2'b00;
      end
    end else begin
      pop_s = 2'b00;
    end
  end

  // Registered output stage and arbiter history; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= {DATA_W{1'b0}};
      out_lane     <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (load_en_s) begin
      if (pop_s[0]) begin
        out_valid    <= 1'b1;
        out_data     <= head_s[0];
        out_lane     <= 1'b0;
        last_grant_r <= 1'b0;
      end else if (pop_s[1]) begin
        out_valid    <= 1'b1;
        out_data     <= head_s[1];
        out_lane     <= 1'b1;
        last_grant_r <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_merger.sv
// Self-checking bench for demux_lane_merger: a queue-based reference model
// predicts merged words into a scoreboard; a negedge monitor checks every
// word the DUT hands downstream. Directed scenarios add constant checks.
module tb_demux_lane_merger;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic       lane;
    logic [7:0] data;
  } out_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in1_valid, out_ready;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              in0_ready, in1_ready, out_valid, out_lane;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  lane0_count, lane1_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: FIFO contents and the output stage.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         hv;
  logic [7:0] hd;
  bit         hl;
  bit         lg;
  out_t       exp_q[$];
  out_t       obs_q[$];
  out_t       ref_q[$];

  always #5 clk = ~clk;

  demux_lane_merger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_ready(out_ready),
    .lane0_count(lane0_count), .lane1_count(lane1_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit r0, r1;
    int g;
    if (rst) begin
      mq0.delete(); mq1.delete(); exp_q.delete();
      hv = 1'b0; hd = 8'h00; hl = 1'b0; lg = 1'b1;
    end else begin
      r0 = (mq0.size() < DEPTH);
      r1 = (mq1.size() < DEPTH);
      if (!hv || out_ready) begin
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = lg ? 0 : 1;
        else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        if (g == 0) begin
          hd = mq0.pop_front(); hl = 1'b0; hv = 1'b1; lg = 1'b0;
          exp_q.push_back({1'b0, hd});
        end else if (g == 1) begin
          hd = mq1.pop_front(); hl = 1'b1; hv = 1'b1; lg = 1'b1;
          exp_q.push_back({1'b1, hd});
        end else begin
          hv = 1'b0;
        end
      end
      if (in0_valid && r0) mq0.push_back(in0_data);
      if (in1_valid && r1) mq1.push_back(in1_data);
    end
  endtask

  task automatic check_state();
    chk("out_valid", out_valid, hv);
    chk("lane0_count", lane0_count, mq0.size());
    chk("lane1_count", lane1_count, mq1.size());
    chk("in0_ready", in0_ready, mq0.size() != DEPTH);
    chk("in1_ready", in1_ready, mq1.size() != DEPTH);
    if (hv) begin
      chk("out_data", out_data, hd);
      chk("out_lane", out_lane, hl);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic set_in(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
  endtask

  task automatic drain(input int n);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_ref(input logic lane, input logic [7:0] data);
    ref_q.push_back({lane, data});
  endtask

  // Compare the observed downstream words against a spec-derived list.
  task automatic expect_obs(input string name);
    chk({name, "_len"}, obs_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++) begin
      chk({name, "_data"}, obs_q[i].data, ref_q[i].data);
      chk({name, "_lane"}, obs_q[i].lane, ref_q[i].lane);
    end
    obs_q.delete();
    ref_q.delete();
  endtask

  // Scoreboard monitor: every accepted output word must match the model.
  always @(negedge clk) begin
    out_t e;
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back({out_lane, out_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got lane %0d data 0x%0h expected no word", out_lane, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_lane", out_lane, e.lane);
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    tick(); tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_lane", out_lane, 1'b0);
    rst = 1'b0;
    tick();

    // Single lane: first word visible one edge after its push.
    obs_q.delete();
    out_ready = 1'b1;
    set_in(1'b1, 8'h11, 1'b0, 8'h00); tick();
    chk("single_lat0", out_valid, 1'b0);
    set_in(1'b1, 8'h22, 1'b0, 8'h00); tick();
    chk("single_lat1_valid", out_valid, 1'b1);
    chk("single_lat1_data", out_data, 8'h11);
    set_in(1'b1, 8'h33, 1'b0, 8'h00); tick();
    drain(4);
    push_ref(1'b0, 8'h11); push_ref(1'b0, 8'h22); push_ref(1'b0, 8'h33);
    expect_obs("single");

    // Reset asserted for two cycles in the middle of traffic.
    out_ready = 1'b0;
    set_in(1'b1, 8'h71, 1'b1, 8'h81); tick();
    set_in(1'b1, 8'h72, 1'b1, 8'h82); tick();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cnt0", lane0_count, 3'd0);
    chk("rst_cnt1", lane1_count, 3'd0);
    chk("rst_rdy0", in0_ready, 1'b1);
    chk("rst_rdy1", in1_ready, 1'b1);
    obs_q.delete();

    // Alternation after reset: lane 0 wins the first tie.
    set_in(1'b1, 8'hA0, 1'b1, 8'hB0); tick();
    set_in(1'b1, 8'hA1, 1'b1, 8'hB1); tick();
    set_in(1'b0, 8'h00, 1'b0, 8'h00); tick();
    drain(6);
    push_ref(1'b0, 8'hA0); push_ref(1'b1, 8'hB0);
    push_ref(1'b0, 8'hA1); push_ref(1'b1, 8'hB1);
    expect_obs("alternate");

    // Backpressure: lane 1 fills to DEPTH, sixth word refused.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(i)); tick();
    end
    chk("full_cnt1", lane1_count, 3'd4);
    chk("full_rdy1", in1_ready, 1'b0);
    set_in(1'b0, 8'h00, 1'b1, 8'hC5); tick();
    chk("full_cnt1_hold", lane1_count, 3'd4);
    drain(8);
    for (int i = 0; i < 5; i++) push_ref(1'b1, 8'hC0 + 8'(i));
    expect_obs("full");

    // Stall: held word stays put while both lanes fill.
    out_ready = 1'b0;
    set_in(1'b1, 8'h5C, 1'b0, 8'h00); tick();
    set_in(1'b0, 8'h00, 1'b0, 8'h00); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'($urandom), 1'b1, 8'($urandom)); tick();
      chk("stall_data", out_data, 8'h5C);
      chk("stall_lane", out_lane, 1'b0);
      chk("stall_cnt0", lane0_count, 3'(i + 1));
    end
    drain(10);
    obs_q.delete();

    // Simultaneous push and pop keep lane 0 at two entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00); tick();
    end
    chk("pp_cnt0_start", lane0_count, 3'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'h50 + 8'(i), 1'b0, 8'h00); tick();
      chk("pp_cnt0", lane0_count, 3'd2);
    end
    drain(6);
    obs_q.delete();

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      set_in(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      tick();
    end
    rst = 1'b0;
    drain(12);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_lane_merger.md
Name: demux_lane_merger

Overview:
- Downstream consumer of the 1:2 demux stage: accepts the two lane outputs (lane 0 / lane 1) as independent valid/ready streams.
- Buffers each lane in its own FIFO.
- Merges both lanes back into a single output stream using a round-robin arbiter; each output word is tagged with its source lane.
- Used wherever demuxed traffic is recombined after per-lane processing.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.
- CNT_W, 3, width of occupancy counters; equals log2(DEPTH)+1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  lane 0 word present.
- in0_data  input  DATA_W  lane 0 word.
- in0_ready  output  1  lane 0 FIFO can accept.
- in1_valid  input  1  lane 1 word present.
- in1_data  input  DATA_W  lane 1 word.
- in1_ready  output  1  lane 1 FIFO can accept.
- out_valid  output  1  merged word present.
- out_data  output  DATA_W  merged word.
- out_lane  output  1  source lane of out_data (0 or 1).
- out_ready  input  1  downstream accepts.
- lane0_count  output  CNT_W  lane 0 FIFO occupancy.
- lane1_count  output  CNT_W  lane 1 FIFO occupancy.

Behaviour:
- Reset (rst high at a rising edge):
  - Both FIFOs emptied; pointers and counts set to 0.
  - out_valid=0, out_data=0, out_lane=0.
  - Internal last_grant=1, so lane 0 wins the first tie.
  - rst mid-operation discards all buffered and held words; no partial outputs.
- Input handshake (per lane):
  - inN_ready = (laneN_count != DEPTH); purely from registered state.
  - A push occurs when inN_valid && inN_ready at a rising edge.
  - When a FIFO is full, inN_ready=0 even if a pop occurs in the same cycle; no write-through when full.
- FIFO storage:
  - Circular buffer, pointers wrap modulo DEPTH.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Output holding register:
  - out_valid/out_data/out_lane form a registered output stage.
  - load_en = !out_valid || out_ready.
- Arbitration on load_en:
  - Both FIFOs non-empty: grant the lane != last_grant.
  - Exactly one FIFO non-empty: grant that lane.
  - Neither non-empty: out_valid clears to 0 (only if load_en).
- On a grant:
  - Pop the head of the granted FIFO into out_data.
  - Set out_lane = granted lane, out_valid=1, last_grant = granted lane.
- Stall: while out_valid && !out_ready, out_data and out_lane hold stable and no pop occurs.
- Latency: a word pushed into an empty lane with an empty output stage at edge k appears with out_valid=1 after edge k+1.
- Throughput: 1 word/cycle with out_ready held high.
- Ordering: order within a lane is preserved; lanes strictly alternate while both are non-empty.
- Counts: laneN_count is a registered value reflecting pushes and pops at each edge.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic.
  - -> out_valid=0, both counts=0, in0_ready=in1_ready=1 on the next cycle.
- Single lane: push lane 0 words 0x11,0x22,0x33 on consecutive cycles, out_ready=1.
  - -> out_data 0x11,0x22,0x33 with out_lane=0, first on the cycle after the first push.
- Alternation: preload lane 0 {0xA0,0xA1}, lane 1 {0xB0,0xB1}, then set out_ready=1.
  - -> output sequence A0(0), B0(1), A1(0), B1(1).
- Full/backpressure: out_ready=0, push 5 words to lane 1 with DEPTH=4.
  - -> first word is taken into the output register, then lane1_count reaches 4 and in1_ready=0.
  - -> the 6th offered word is not accepted.
  - -> release out_ready and confirm all 5 accepted words emerge in order.
- Stall hold: out_valid=1 with out_data=0x5C, hold out_ready=0 for 3 cycles while pushing both lanes.
  - -> out_data and out_lane are unchanged all 3 cycles; counts rise.
- Simultaneous push/pop: lane 0 at count=2, in0_valid=1, out_ready=1, lane 1 empty.
  - -> lane0_count stays 2 while streaming.
